// File: rtl/n_mac_pkg.sv
// Shared types and defaults for the N-MAC controller and its accumulator sequencer.
package n_mac_pkg;

    localparam int unsigned N_ADDR_W = 13;
    localparam int unsigned N_DATA_W = 32;
    localparam logic [31:0] FP_ZERO  = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        REDUCE,
        DONE
    } acc_state_t;

endpackage

// File: rtl/n_acc_reduce.sv
// Lane reduction: pairs adder results through a single hold register until one partial remains.
module n_acc_reduce
    import n_mac_pkg::*;
#(
    parameter int unsigned ADDR_W  = N_ADDR_W,
    parameter int unsigned DATA_W  = N_DATA_W,
    parameter int unsigned ADD_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_i,
    input  logic              en_i,
    input  logic [ADDR_W-1:0] len_i,
    input  logic              feed_issue_i,
    input  logic              feed_take_i,
    input  logic              vout_i,
    input  logic [DATA_W-1:0] sum_i,
    output logic              pair_o,
    output logic [DATA_W-1:0] hold_o,
    output logic [DATA_W-1:0] final_o,
    output logic              done_o
);

    localparam int unsigned CNT_W = 4;

    logic [CNT_W-1:0]  live_q, live_d;
    logic [CNT_W-1:0]  infl_q, infl_d;
    logic              full_q, full_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              arrive;
    logic              capture;

    always_comb begin
        arrive  = en_i & vout_i;
        pair_o  = arrive & full_q;
        capture = arrive & ~full_q;
        hold_d  = hold_q;
        full_d  = full_q;
        live_d  = live_q;
        // Every issue (feed or pair) adds one op in flight; every consumed result removes one.
        infl_d  = infl_q + CNT_W'(feed_issue_i) + CNT_W'(pair_o)
                - CNT_W'(feed_take_i) - CNT_W'(arrive);
        if (capture) begin
            hold_d = sum_i;
            full_d = 1'b1;
        end
        if (pair_o) begin
            full_d = 1'b0;
            live_d = live_q - CNT_W'(1);
        end
        if (init_i) begin
            hold_d = DATA_W'(FP_ZERO);
            full_d = 1'b0;
            infl_d = '0;
            live_d = (len_i >= ADDR_W'(ADD_LAT - 1)) ? CNT_W'(ADD_LAT)
                                                     : CNT_W'(len_i) + CNT_W'(1);
        end
        done_o  = en_i && (live_q == CNT_W'(1)) && full_d && (infl_d == '0);
        final_o = hold_d;
        hold_o  = hold_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q <= '0;
            infl_q <= '0;
            full_q <= 1'b0;
            hold_q <= '0;
        end else begin
            live_q <= live_d;
            infl_q <= infl_d;
            full_q <= full_d;
            hold_q <= hold_d;
        end
    end

endmodule

// File: rtl/n_acc_sequencer.sv
// Accumulator sequencer: streams acc_len+1 products through the pipelined adder and returns their sum.
module n_acc_sequencer
    import n_mac_pkg::*;
#(
    parameter int unsigned ADDR_W  = N_ADDR_W,
    parameter int unsigned DATA_W  = N_DATA_W,
    parameter int unsigned ADD_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acc_start,
    input  logic [ADDR_W-1:0] acc_len,
    output logic [ADDR_W-1:0] ram_addr_rd,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic [DATA_W-1:0] add_a,
    output logic [DATA_W-1:0] add_b,
    output logic              add_valid_in,
    input  logic [DATA_W-1:0] add_sum,
    input  logic              add_valid_out,
    output logic [DATA_W-1:0] acc_result,
    output logic              acc_finish,
    output logic              busy
);

    localparam int unsigned FLUSH_W = 4;

    acc_state_t        state_q, state_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              rd_pend_q, rd_pend_d;
    logic              last_rd_q, last_rd_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [FLUSH_W-1:0] flush_q;
    logic              vout;
    logic              feed_issue, feed_take, red_init, red_en;
    logic              pair, red_done;
    logic [DATA_W-1:0] hold, final_sum;

    // Results still draining from before a reset are masked for one adder latency.
    assign vout        = add_valid_out & (flush_q == '0);
    assign ram_addr_rd = addr_q;
    assign acc_result  = result_q;

    n_acc_reduce #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .ADD_LAT (ADD_LAT)
    ) u_reduce (
        .clk          (clk),
        .rst          (rst),
        .init_i       (red_init),
        .en_i         (red_en),
        .len_i        (acc_len),
        .feed_issue_i (feed_issue),
        .feed_take_i  (feed_take),
        .vout_i       (vout),
        .sum_i        (add_sum),
        .pair_o       (pair),
        .hold_o       (hold),
        .final_o      (final_sum),
        .done_o       (red_done)
    );

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        addr_d       = addr_q;
        idx_d        = idx_q;
        rd_pend_d    = 1'b0;
        last_rd_d    = last_rd_q;
        result_d     = result_q;
        feed_issue   = 1'b0;
        feed_take    = 1'b0;
        red_init     = 1'b0;
        red_en       = 1'b0;
        add_a        = DATA_W'(FP_ZERO);
        add_b        = DATA_W'(FP_ZERO);
        add_valid_in = 1'b0;
        acc_finish   = 1'b0;
        busy         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (acc_start) begin
                    len_d     = acc_len;
                    addr_d    = '0;
                    idx_d     = '0;
                    last_rd_d = 1'b0;
                    red_init  = 1'b1;
                    state_d   = FEED;
                end
            end
            FEED: begin
                busy = 1'b1;
                if (!last_rd_q) begin
                    rd_pend_d = 1'b1;
                    if (addr_q == len_q) last_rd_d = 1'b1;
                    else                 addr_d    = addr_q + ADDR_W'(1);
                end
                if (rd_pend_q) begin
                    feed_issue   = 1'b1;
                    add_valid_in = 1'b1;
                    add_a        = ram_rd_data;
                    if (idx_q >= ADDR_W'(ADD_LAT)) begin
                        feed_take = 1'b1;
                        add_b     = add_sum;
                    end
                    if (idx_q == len_q) state_d = REDUCE;
                    else                idx_d   = idx_q + ADDR_W'(1);
                end
            end
            REDUCE: begin
                busy   = 1'b1;
                red_en = 1'b1;
                if (pair) begin
                    add_valid_in = 1'b1;
                    add_a        = hold;
                    add_b        = add_sum;
                end
                if (red_done) begin
                    result_d = final_sum;
                    state_d  = DONE;
                end
            end
            DONE: begin
                acc_finish = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            addr_q    <= '0;
            idx_q     <= '0;
            rd_pend_q <= 1'b0;
            last_rd_q <= 1'b0;
            result_q  <= DATA_W'(FP_ZERO);
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            addr_q    <= addr_d;
            idx_q     <= idx_d;
            rd_pend_q <= rd_pend_d;
            last_rd_q <= last_rd_d;
            result_q  <= result_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                flush_q <= FLUSH_W'(ADD_LAT);
        else if (flush_q != '0) flush_q <= flush_q - FLUSH_W'(1);
    end

endmodule
